// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte/strobe/flags out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;

  modport master (
    input  rx,
    output data_rx, rx_valid, rx_busy, parity_err, frame_err
  );

  modport slave (
    output rx,
    input  data_rx, rx_valid, rx_busy, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8 data bits, parity, 1 stop, 2-of-3 majority.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter bit PARITY     = 1'b0
) (
  input  logic     baud_clk,
  input  logic     reset,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_FIRST = TW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    hist;
  logic          fall;
  logic          maj;
  logic          decide;

  logic [TW-1:0] tick;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          stop_bit;
  logic          done;

  logic          shift_en;
  logic          par_en;
  logic          stop_en;

  logic [7:0]    data_q;
  logic          valid_q;
  logic          perr_q;
  logic          ferr_q;

  assign rx_s = sync[1];
  assign fall = rx_prev & ~rx_s;
  // hist holds the two previous samples; the live rx_s is the third.
  assign maj    = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
  assign decide = (state != S_IDLE) && (tick == TICK_MID);

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      hist    <= 2'b11;
      state   <= S_IDLE;
    end else begin
      sync    <= {sync[0], bus.rx};
      rx_prev <= rx_s;
      hist    <= {hist[0], rx_s};
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) state_next = S_START;
      end
      S_START: begin
        if (decide) state_next = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 4'd8) state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop lets a start bit right after the stop bit be caught.
        if (decide) begin
          stop_en    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Position counter: at each active edge bit_idx*OVERSAMPLE+tick is the tick offset from T0.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      tick    <= '0;
      bit_idx <= 4'd0;
    end else if (state == S_IDLE) begin
      if (fall) begin
        tick    <= TICK_FIRST;
        bit_idx <= 4'd0;
      end
    end else if (tick == TICK_LAST) begin
      tick    <= '0;
      bit_idx <= bit_idx + 4'd1;
    end else begin
      tick    <= tick + TW'(1);
    end
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
      stop_bit <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= stop_en;
      if (shift_en) shreg    <= {maj, shreg[7:1]};
      if (par_en)   par_bit  <= maj;
      if (stop_en)  stop_bit <= maj;
    end
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) begin
        data_q <= shreg;
        perr_q <= ((^shreg) ^ par_bit) != PARITY;
        ferr_q <= ~stop_bit;
      end
    end
  end

  assign bus.data_rx    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.rx_busy    = (state != S_IDLE);
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed frames into even- and odd-parity receivers sharing one line.
module tb_uart_rx;
  localparam int OS = 8;

  logic baud_clk = 1'b0;
  logic reset    = 1'b1;

  always #5 baud_clk = ~baud_clk;

  uart_rx_if even_if();
  uart_rx_if odd_if();

  uart_rx #(.OVERSAMPLE(OS), .PARITY(1'b0)) dut (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (even_if)
  );

  uart_rx #(.OVERSAMPLE(OS), .PARITY(1'b1)) dut_odd (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (odd_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int         vcyc[$];
  logic [7:0] vdata[$];
  int         rise_cyc = -1;
  int         fall_cyc = -1;
  logic       busy_q   = 1'b0;

  always @(posedge baud_clk) cyc <= cyc + 1;

  always @(negedge baud_clk) begin
    if (even_if.rx_valid) begin
      vcyc.push_back(cyc);
      vdata.push_back(even_if.data_rx);
    end
    if (even_if.rx_busy && !busy_q) rise_cyc = cyc;
    if (!even_if.rx_busy && busy_q) fall_cyc = cyc;
    busy_q = even_if.rx_busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_vec++;
    if (got !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  task automatic set_line(input logic b);
    even_if.rx = b;
    odd_if.rx  = b;
  endtask

  task automatic idle(input int n);
    set_line(1'b1);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int t_start);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 11; i++) begin
      set_line(f[i]);
      repeat (OS) @(negedge baud_clk);
    end
  endtask

  function automatic int vcyc_at(input int idx);
    return (vcyc.size() > idx) ? vcyc[idx] : -1;
  endfunction

  function automatic logic [7:0] vdata_at(input int idx);
    return (vdata.size() > idx) ? vdata[idx] : 8'hxx;
  endfunction

  initial begin
    int t, t2, n0;
    logic [10:0] f;

    set_line(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge baud_clk);
    reset = 1'b0;
    repeat (2) @(negedge baud_clk);

    check("reset_data",  even_if.data_rx,    8'h00);
    check("reset_valid", even_if.rx_valid,   1'b0);
    check("reset_busy",  even_if.rx_busy,    1'b0);
    check("reset_perr",  even_if.parity_err, 1'b0);
    check("reset_ferr",  even_if.frame_err,  1'b0);

    // 0xA5 clean frame with timing
    n0 = vcyc.size();
    send_frame(8'hA5, 1'b0, 1'b1, t);
    idle(6);
    check("a5_count",   vcyc.size() - n0, 1);
    check("a5_data",    even_if.data_rx, 8'hA5);
    check("a5_perr",    even_if.parity_err, 1'b0);
    check("a5_ferr",    even_if.frame_err, 1'b0);
    check("a5_latency", vcyc_at(n0) - t, 88);
    check("a5_busy_up", rise_cyc - t, 3);
    check("a5_busy_dn", fall_cyc - t, 87);

    // parity error then recovery
    send_frame(8'h01, 1'b0, 1'b1, t);
    idle(6);
    check("p01_data",     even_if.data_rx, 8'h01);
    check("p01_perr",     even_if.parity_err, 1'b1);
    check("p01_odd_perr", odd_if.parity_err, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1, t);
    idle(6);
    check("p03_data",     even_if.data_rx, 8'h03);
    check("p03_perr",     even_if.parity_err, 1'b0);
    check("p03_odd_perr", odd_if.parity_err, 1'b1);

    // framing error, then line stuck low
    n0 = vcyc.size();
    send_frame(8'h3C, 1'b0, 1'b0, t);
    repeat (3 * 11 * OS) @(negedge baud_clk);
    check("fe_count", vcyc.size() - n0, 1);
    check("fe_data",  vdata_at(n0), 8'h3C);
    check("fe_ferr",  even_if.frame_err, 1'b1);
    check("fe_perr",  even_if.parity_err, 1'b0);
    check("fe_busy",  even_if.rx_busy, 1'b0);
    idle(16);
    send_frame(8'h55, 1'b0, 1'b1, t);
    idle(6);
    check("r55_count", vcyc.size() - n0, 2);
    check("r55_data",  even_if.data_rx, 8'h55);
    check("r55_ferr",  even_if.frame_err, 1'b0);
    check("r55_perr",  even_if.parity_err, 1'b0);

    // two-tick glitch is a false start
    n0 = vcyc.size();
    t  = cyc;
    set_line(1'b0);
    repeat (2) @(negedge baud_clk);
    set_line(1'b1);
    repeat (20) @(negedge baud_clk);
    check("gl_count",   vcyc.size() - n0, 0);
    check("gl_busy_up", rise_cyc - t, 3);
    check("gl_busy_dn", fall_cyc - t, 7);
    check("gl_busy",    even_if.rx_busy, 1'b0);
    check("gl_data",    even_if.data_rx, 8'h55);
    check("gl_ferr",    even_if.frame_err, 1'b0);

    // back-to-back frames, no idle gap
    n0 = vcyc.size();
    send_frame(8'h00, 1'b0, 1'b1, t);
    send_frame(8'hFF, 1'b0, 1'b1, t2);
    idle(6);
    check("bb_count",   vcyc.size() - n0, 2);
    check("bb_lat",     vcyc_at(n0) - t, 88);
    check("bb_spacing", vcyc_at(n0 + 1) - vcyc_at(n0), 11 * OS);
    check("bb_data0",   vdata_at(n0), 8'h00);
    check("bb_data1",   vdata_at(n0 + 1), 8'hFF);
    check("bb_perr",    even_if.parity_err, 1'b0);
    check("bb_ferr",    even_if.frame_err, 1'b0);

    // reset in the middle of data bit 5
    n0 = vcyc.size();
    f  = {1'b1, 1'b0, 8'h7E, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_line(f[i]);
      repeat (OS) @(negedge baud_clk);
    end
    set_line(f[6]);
    repeat (OS / 2) @(negedge baud_clk);
    check("mid_busy", even_if.rx_busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge baud_clk);
    check("rst_data",  even_if.data_rx,    8'h00);
    check("rst_valid", even_if.rx_valid,   1'b0);
    check("rst_busy",  even_if.rx_busy,    1'b0);
    check("rst_perr",  even_if.parity_err, 1'b0);
    check("rst_ferr",  even_if.frame_err,  1'b0);
    set_line(1'b1);
    reset = 1'b0;
    idle(16);
    check("rst_count", vcyc.size() - n0, 0);
    send_frame(8'h7E, 1'b0, 1'b1, t);
    idle(6);
    check("r7e_count", vcyc.size() - n0, 1);
    check("r7e_data",  even_if.data_rx, 8'h7E);
    check("r7e_perr",  even_if.parity_err, 1'b0);
    check("r7e_ferr",  even_if.frame_err, 1'b0);

    // 0x00 with parity bit 1: good for odd, bad for even
    send_frame(8'h00, 1'b1, 1'b1, t);
    idle(6);
    check("odd_data",  odd_if.data_rx, 8'h00);
    check("odd_perr",  odd_if.parity_err, 1'b0);
    check("odd_ferr",  odd_if.frame_err, 1'b0);
    check("even_perr", even_if.parity_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers 11-bit frames (start, 8 data LSB first, parity, stop) from the serial line and presents each byte with a one-cycle valid strobe and error flags. It uses the same frame format and parity convention as the team's `uart_tx` and sits between the FPGA's serial input pin and the command/data handling logic. It runs on an oversampling `baud_clk` produced by `clk_divider` at `OVERSAMPLE` times the line baud rate.

## Interface
- `OVERSAMPLE`, 8: `baud_clk` ticks per bit. Must be even and at least 4.
- `PARITY`, 0: 0 selects even parity, 1 selects odd parity.
- `baud_clk`  in  1  oversampling clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high. Clock is `baud_clk`.
- `rx`  in  1  raw serial line, idle high, asynchronous to `baud_clk`.
- `data_rx`  out  8  last received byte; held until the next `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `rx_busy`  out  1  high from start detection until the stop decision.
- `parity_err`  out  1  parity mismatch on the last frame; updated with `rx_valid`.
- `frame_err`  out  1  stop bit sampled low on the last frame; updated with `rx_valid`.

## Operation
- **Synchronizer:** `rx` passes through a 2-FF synchronizer (`rx_s`), reset to 1.
- **Edge detector:** compares `rx_s` to its previous value. A start is armed only by a 1→0 transition, so a line held low never re-triggers.
- **Bit counter:** tick counter 0..OVERSAMPLE-1 and bit index 0..10.
- **Bit sampling:**
  - Bit k has nominal center c = k·OVERSAMPLE + OVERSAMPLE/2 ticks after T0, the edge where `rx_s` is first seen 0.
  - Samples are taken at c-1, c and c+1. A 2-of-3 majority gives the bit value, decided at c+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on the `rx_s` falling edge. `rx_busy` is set.
  - START: if the majority is 1, the start is false. Go to IDLE and clear `rx_busy`; no `rx_valid`, flags unchanged. If the majority is 0, go to DATA.
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the stop decision, register the outputs and go to IDLE.
- **Stop decision outputs:**
  - `data_rx` ← shift register.
  - `parity_err` ← (^data ^ parity_bit) != PARITY.
  - `frame_err` ← (stop majority == 0).
  - `rx_valid` ← 1 for exactly one cycle.
  - `rx_busy` ← 0.
- **Errored frames:** the byte and `rx_valid` are still delivered; the consumer decides what to do via the flags.
- **Back-to-back frames:** IDLE is re-entered at mid-stop, so a start bit immediately after the stop bit is caught.
- **Reset:** asserting `reset` mid-frame aborts the frame. Nothing is delivered and the FSM returns to IDLE.

## Timing
- **Reset values:** `data_rx` = 0x00, `rx_valid` = 0, `rx_busy` = 0, `parity_err` = 0, `frame_err` = 0. FSM in IDLE, synchronizer = 1.
- **Input latency:** 2 `baud_clk` edges from a raw `rx` change to `rx_s`.
- **Start detect:** `rx_busy` rises on edge T0+1.
- **Frame latency:** the stop decision is at T0 + 10·OVERSAMPLE + OVERSAMPLE/2 + 1. `rx_valid`, `data_rx` and the flags update on the following edge, T0+86 for OVERSAMPLE=8. `rx_valid` drops one edge later.
- **Minimum frame spacing:** 11 bit times. A falling edge during STOP before the stop decision is ignored.
- **Clock tolerance:** ±4% baud mismatch is tolerated at OVERSAMPLE=8.
- **Flag lifetime:** flags and `data_rx` are stable between `rx_valid` pulses. They are never cleared except by reset.

## Test plan
- Even parity, send 0xA5 with parity 0 and stop 1 → one `rx_valid` pulse, `data_rx` = 0xA5, `parity_err` = 0, `frame_err` = 0. `rx_busy` high from T0+1 and low after the stop decision.
- Even parity, send 0x01 with parity bit 0 → `data_rx` = 0x01, `parity_err` = 1. Then send 0x03 with parity 0 → `parity_err` back to 0.
- Send 0x3C with stop bit 0, then hold `rx` low for 3 frames → a single `rx_valid` with `frame_err` = 1 and no further `rx_valid` until a high→low transition. Release and send 0x55 → received cleanly.
- Glitch low for 2 ticks, then high → no `rx_valid`, `rx_busy` returns to 0 after the start decision, outputs unchanged.
- Back-to-back 0x00 then 0xFF with no idle gap → two `rx_valid` pulses exactly 11·OVERSAMPLE cycles apart, carrying 0x00 then 0xFF, no errors.
- Assert `reset` at bit 5 of a frame, release, then send 0x7E → aborted frame produces no `rx_valid`, all outputs at reset values, 0x7E received correctly. With PARITY=1, 0x00 with parity bit 1 → `parity_err` = 0.
